// File: rtl/regarr_arbiter_pkg.sv
// Shared types and helpers for the round-robin register-array arbiter.
// Holds the FSM state encoding, default sizes and the pointer-advance function.
package regarr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DEPTH  = 3;
   localparam int DEF_WIDTH  = 3;
   localparam int DEF_ADDR_W = 2;

   function automatic int rr_next(int idx, int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regarr_arbiter_if.sv
// Requester-side bus of the register-array arbiter: packed per-requester
// request/payload lanes plus the shared grant/acknowledge/response signals.
interface regarr_if
   import regarr_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WIDTH  = DEF_WIDTH
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        we;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ*WIDTH-1:0]  wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic [WIDTH-1:0]        rdata;
   logic                    err;
   logic                    busy;

   modport master (
      output req, we, addr, wdata,
      input  gnt, ack, rdata, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, ack, rdata, err, busy
   );
endinterface

// File: rtl/regarr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request found scanning
// ptr, ptr+1, ... with wrap-around.
module rr_pick
   import regarr_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = $clog2(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] winner
);
   int idx;

   // Scan farthest offset first so the nearest set bit after ptr overwrites last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end
endmodule

// File: rtl/regarr_arbiter.sv
// Round-robin arbiter in front of a small register array: one read or write
// per grant, IDLE -> ACCESS -> DONE, with registered one-hot gnt/ack.
module regarr_arbiter
   import regarr_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic     clock,
   input  logic     clear_n,
   regarr_if.slave  bus
);
   localparam int IDX_W = $clog2(N_REQ);

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  winner_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [WIDTH-1:0]  wdata_r;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  rdata_r;
   logic              err_r;
   logic [N_REQ-1:0]  gnt_r;
   logic [N_REQ-1:0]  ack_r;
   logic              busy_r;
   logic              found;
   logic [IDX_W-1:0]  pick;
   logic              in_range;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .found  (found),
      .winner (pick)
   );

   assign in_range = (int'(addr_r) < DEPTH);

   // The payload is captured only when leaving IDLE; later input changes are ignored.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state    <= IDLE;
         ptr      <= '0;
         winner_r <= '0;
         we_r     <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
         err_r    <= 1'b0;
         gnt_r    <= '0;
         ack_r    <= '0;
         busy_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               ack_r <= '0;
               if (found) begin
                  winner_r <= pick;
                  we_r     <= bus.we[pick];
                  addr_r   <= bus.addr[int'(pick)*ADDR_W +: ADDR_W];
                  wdata_r  <= bus.wdata[int'(pick)*WIDTH +: WIDTH];
                  gnt_r    <= N_REQ'(1) << pick;
                  busy_r   <= 1'b1;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               gnt_r <= '0;
               ack_r <= N_REQ'(1) << winner_r;
               if (in_range) begin
                  err_r <= 1'b0;
                  if (we_r) begin
                     mem[addr_r] <= wdata_r;
                     rdata_r     <= wdata_r;
                  end else begin
                     rdata_r <= mem[addr_r];
                  end
               end else begin
                  err_r   <= 1'b1;
                  rdata_r <= '0;
               end
               state <= DONE;
            end
            DONE: begin
               ack_r  <= '0;
               busy_r <= 1'b0;
               ptr    <= IDX_W'(rr_next(int'(winner_r), N_REQ));
               state  <= IDLE;
            end
            default: begin
               gnt_r  <= '0;
               ack_r  <= '0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_r;
   assign bus.ack   = ack_r;
   assign bus.rdata = rdata_r;
   assign bus.err   = err_r;
   assign bus.busy  = busy_r;
endmodule

// File: tb/tb_regarr_arbiter.sv
// Bench for regarr_arbiter: directed scenarios plus randomized traffic checked
// against an array/pointer reference model derived from the arbitration rules.
module tb_regarr_arbiter;
   localparam int N  = 4;
   localparam int D  = 3;
   localparam int W  = 3;
   localparam int AW = 2;

   logic clock   = 1'b0;
   logic clear_n = 1'b0;

   regarr_if #(.N_REQ(N), .ADDR_W(AW), .WIDTH(W)) bus ();

   regarr_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W), .ADDR_W(AW)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;
   int mdl_mem [D];
   int mdl_ptr;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) mdl_mem[i] = 0;
      mdl_ptr = 0;
   endtask

   task automatic drive(int i, bit wr, int a, int d);
      bus.req[i]             = 1'b1;
      bus.we[i]              = wr;
      bus.addr[i*AW +: AW]   = AW'(a);
      bus.wdata[i*W +: W]    = W'(d);
   endtask

   function automatic int model_pick();
      for (int k = 0; k < N; k++) begin
         if (bus.req[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
      end
      return -1;
   endfunction

   // Starts at a negedge in IDLE with requests already driven; ends at a negedge in IDLE.
   task automatic txn(string tag, bit drop, bit mutate = 1'b0, int m_addr = 0, int m_data = 0);
      int w, a, d;
      bit wr;
      logic [31:0] erd;
      logic [31:0] eerr;
      w = model_pick();
      if (w < 0) return;
      wr = bus.we[w];
      a  = int'(bus.addr[w*AW +: AW]);
      d  = int'(bus.wdata[w*W +: W]);
      @(posedge clock); @(negedge clock);
      check({tag, " gnt"},  32'(bus.gnt), 32'(1) << w);
      check({tag, " ack0"}, 32'(bus.ack), 32'd0);
      check({tag, " busy1"}, 32'(bus.busy), 32'd1);
      if (mutate) begin
         bus.addr[w*AW +: AW] = AW'(m_addr);
         bus.wdata[w*W +: W]  = W'(m_data);
      end
      @(posedge clock); @(negedge clock);
      if (a < D) begin
         eerr = 0;
         if (wr) begin
            mdl_mem[a] = d;
            erd = 32'(d);
         end else begin
            erd = 32'(mdl_mem[a]);
         end
      end else begin
         eerr = 1;
         erd  = 0;
      end
      mdl_ptr = (w + 1) % N;
      check({tag, " ack"},   32'(bus.ack), 32'(1) << w);
      check({tag, " gnt0"},  32'(bus.gnt), 32'd0);
      check({tag, " rdata"}, 32'(bus.rdata), erd);
      check({tag, " err"},   32'(bus.err), eerr);
      if (drop) bus.req[w] = 1'b0;
      @(posedge clock); @(negedge clock);
      check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, " idle_ack"},  32'(bus.ack), 32'd0);
   endtask

   initial begin
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      model_reset();
      clear_n = 1'b0;
      repeat (2) @(negedge clock);
      clear_n = 1'b1;
      @(negedge clock);
      check("rst gnt",   32'(bus.gnt), 32'd0);
      check("rst ack",   32'(bus.ack), 32'd0);
      check("rst busy",  32'(bus.busy), 32'd0);
      check("rst rdata", 32'(bus.rdata), 32'd0);
      check("rst err",   32'(bus.err), 32'd0);
      repeat (3) begin
         @(negedge clock);
         check("idle busy", 32'(bus.busy), 32'd0);
      end

      drive(1, 1'b0, 2, 0);
      txn("rd1", 1'b1);

      drive(0, 1'b1, 1, 5);
      txn("wr0", 1'b1);
      drive(2, 1'b0, 1, 0);
      txn("rd2", 1'b1);

      // Bring the pointer back to 0 before the contention scenario.
      drive(3, 1'b0, 0, 0);
      txn("align", 1'b1);
      for (int i = 0; i < N; i++) drive(i, 1'b0, i % D, 0);
      for (int k = 0; k < 5; k++) txn("rr", 1'b0);
      bus.req = '0;

      drive(3, 1'b1, 3, 7);
      txn("oor", 1'b1);
      for (int a = 0; a < D; a++) begin
         drive(0, 1'b0, a, 0);
         txn("oor_rd", 1'b1);
      end

      drive(2, 1'b1, 0, 6);
      txn("samp", 1'b1, 1'b1, 2, 1);
      drive(0, 1'b0, 0, 0);
      txn("samp_rd0", 1'b1);
      drive(0, 1'b0, 2, 0);
      txn("samp_rd2", 1'b1);

      for (int it = 0; it < 40; it++) begin
         bus.req = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            bus.we[i]            = 1'($urandom_range(0, 1));
            bus.addr[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
            bus.wdata[i*W +: W]  = W'($urandom_range(0, (1 << W) - 1));
         end
         txn("rnd", 1'($urandom_range(0, 1)));
      end

      bus.req = '0;
      drive(0, 1'b1, 0, 4);
      @(posedge clock); @(negedge clock);
      check("mid gnt", 32'(bus.gnt), 32'd1);
      clear_n = 1'b0;
      #1;
      check("mid rst gnt",   32'(bus.gnt), 32'd0);
      check("mid rst ack",   32'(bus.ack), 32'd0);
      check("mid rst busy",  32'(bus.busy), 32'd0);
      check("mid rst rdata", 32'(bus.rdata), 32'd0);
      bus.req = '0;
      model_reset();
      @(negedge clock);
      clear_n = 1'b1;
      @(negedge clock);
      for (int a = 0; a < D; a++) begin
         drive(0, 1'b0, a, 0);
         txn("post_rst_rd", 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
